// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver (8N1; 8E1 when UART_RX_PARITY_EN is defined).
// rdy/rdy_clr: rdy rises with a new byte in data_out and falls on the edge after rdy_clr; a new byte wins over rdy_clr.
module uart_receiver #(
    parameter int OVS_DIV = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rdy_clr,
    output logic       rdy,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
        , PARITY  = 3'd5
`endif
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  sync;
    logic        rxs;
    logic [15:0] div_cnt;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic        last_tick;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_bad;
    logic        bit_sample;
    logic        stop_sample;

    always_ff @(posedge clk) begin
        if (rst) sync <= 2'b11;
        else     sync <= {sync[0], rx};
    end
    assign rxs = sync[1];

    // The divider is held at zero while idle so every frame starts with a fresh phase.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) div_cnt <= '0;
        else if (tick)            div_cnt <= '0;
        else                      div_cnt <= div_cnt + 16'd1;
    end
    assign tick      = (div_cnt == 16'(OVS_DIV - 1));
    assign last_tick = tick && (tick_cnt == 4'd15);

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) begin
            tick_cnt <= '0;
        end else if (tick) begin
            if (state == START && tick_cnt == 4'd7) tick_cnt <= '0;
            else                                    tick_cnt <= tick_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE) bit_cnt <= '0;
        else if (bit_sample)      bit_cnt <= bit_cnt + 3'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)             shift <= '0;
        else if (bit_sample) shift <= {rxs, shift[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || state == IDLE)                par_bad <= 1'b0;
        else if (state == PARITY && last_tick)   par_bad <= (rxs != ^shift);
    end
`else
    assign par_bad = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rxs) state_next = START;
            START:     if (tick && tick_cnt == 4'd7) state_next = rxs ? IDLE : DATA;
            DATA: begin
                if (last_tick && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY:    if (last_tick) state_next = STOP;
`endif
            STOP:      if (last_tick) state_next = rxs ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy        = (state != IDLE);
        bit_sample  = (state == DATA) && last_tick;
        stop_sample = (state == STOP) && last_tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy       <= 1'b0;
            data_out  <= 8'h00;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (stop_sample) begin
            frame_err <= !rxs;
            if (rxs && !par_bad) begin
                data_out <= shift;
                rdy      <= 1'b1;
                if (rdy && !rdy_clr) overrun <= 1'b1;
            end else if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end else if (rdy_clr) begin
            rdy     <= 1'b0;
            overrun <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)              parity_err <= 1'b0;
        else if (stop_sample) parity_err <= par_bad;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
